// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage and a variable-latency data memory.
//
// Handshake: the stage raises mem_req for exactly one cycle, together with
// mem_wr/mem_addr/mem_wdata. The memory later answers with a one-cycle
// mem_done pulse, and mem_rdata is valid only in that cycle. At most one
// access is outstanding, so mem_req and mem_done never overlap.
//
// Signals:
//   mem_req   stage -> mem  one-cycle access request
//   mem_wr    stage -> mem  1 = store, 0 = load (valid with mem_req)
//   mem_addr  stage -> mem  byte address (valid with mem_req)
//   mem_wdata stage -> mem  store data (valid with mem_req)
//   mem_rdata mem -> stage  load data (valid with mem_done)
//   mem_done  mem -> stage  one-cycle completion pulse
interface mem_access_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage access controller between the EX/MEM and MEM/WB registers.
// Issues loads/stores over the mem_access_stage_if bus, stalls upstream while
// an access is outstanding, registers the write-back payload, traps
// misaligned accesses and freezes the pipe after a halt.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_*              EX/MEM payload (valid, mem_read, mem_write, addr,
//                     wdata, reg_write, mem_to_reg, halt, wreg)
//   stall             hold EX/MEM and all earlier stages
//   mem               data-memory bus (master side)
//   out_*             MEM/WB payload (valid, reg_write, mem_to_reg, halt,
//                     err, wreg, alu, mem_data)
//   dbg_state         current FSM state (0 IDLE, 1 WAIT, 2 HALTED)
module mem_access_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic               in_reg_write,
  input  logic               in_mem_to_reg,
  input  logic               in_halt,
  input  logic [REG_W-1:0]   in_wreg,
  output logic               stall,
  mem_access_stage_if.master mem,
  output logic               out_valid,
  output logic               out_reg_write,
  output logic               out_mem_to_reg,
  output logic               out_halt,
  output logic               out_err,
  output logic [REG_W-1:0]   out_wreg,
  output logic [DATA_W-1:0]  out_alu,
  output logic [DATA_W-1:0]  out_mem_data,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state, state_nx;

  logic mem_op;
  logic misaligned;

  // Copy of the instruction whose access is outstanding; EX/MEM may change
  // underneath us while we wait, so the WB payload comes from here.
  logic              cap_load;
  logic              cap_reg_write;
  logic              cap_mem_to_reg;
  logic              cap_halt;
  logic [REG_W-1:0]  cap_wreg;
  logic [ADDR_W-1:0] cap_addr;

  assign mem_op     = in_valid & (in_mem_read | in_mem_write);
  assign misaligned = in_addr[0];
  assign dbg_state  = state;

  always_comb begin
    state_nx      = state;
    stall         = 1'b0;
    mem.mem_req   = 1'b0;
    // Read and write together is a load, so write only when read is absent.
    mem.mem_wr    = in_mem_write & ~in_mem_read;
    mem.mem_addr  = in_addr;
    mem.mem_wdata = in_wdata;
    case (state)
      S_IDLE: begin
        if (mem_op) begin
          if (!misaligned) begin
            mem.mem_req = 1'b1;
            stall       = 1'b1;
            state_nx    = S_WAIT;
          end else begin
            state_nx = S_HALTED;
          end
        end else if (in_valid && in_halt) begin
          state_nx = S_HALTED;
        end
      end
      S_WAIT: begin
        if (mem.mem_done) begin
          state_nx = cap_halt ? S_HALTED : S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      S_HALTED: begin
        stall = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cap_load       <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_mem_to_reg <= 1'b0;
      cap_halt       <= 1'b0;
      cap_wreg       <= '0;
      cap_addr       <= '0;
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_halt       <= 1'b0;
      out_err        <= 1'b0;
      out_wreg       <= '0;
      out_alu        <= '0;
      out_mem_data   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (mem_op && !misaligned) begin
            cap_load       <= in_mem_read;
            cap_reg_write  <= in_reg_write;
            cap_mem_to_reg <= in_mem_to_reg;
            cap_halt       <= in_halt;
            cap_wreg       <= in_wreg;
            cap_addr       <= in_addr;
            // WB sees a bubble while the access is in flight.
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_halt       <= 1'b0;
            out_err        <= 1'b0;
            out_wreg       <= '0;
            out_alu        <= '0;
            out_mem_data   <= '0;
          end else if (mem_op) begin
            // Misaligned trap: reported as a halting, non-writing instruction.
            out_valid      <= 1'b1;
            out_reg_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_halt       <= 1'b1;
            out_err        <= 1'b1;
            out_wreg       <= in_wreg;
            out_alu        <= DATA_W'(in_addr);
            out_mem_data   <= '0;
          end else begin
            out_valid      <= in_valid;
            out_reg_write  <= in_valid & in_reg_write;
            out_mem_to_reg <= in_mem_to_reg;
            out_halt       <= in_valid & in_halt;
            out_err        <= 1'b0;
            out_wreg       <= in_wreg;
            out_alu        <= DATA_W'(in_addr);
            out_mem_data   <= '0;
          end
        end
        S_WAIT: begin
          if (mem.mem_done) begin
            out_valid      <= 1'b1;
            out_reg_write  <= cap_reg_write;
            out_mem_to_reg <= cap_mem_to_reg;
            out_halt       <= cap_halt;
            out_err        <= 1'b0;
            out_wreg       <= cap_wreg;
            out_alu        <= DATA_W'(cap_addr);
            out_mem_data   <= cap_load ? mem.mem_rdata : '0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        S_HALTED: begin
          // halt/err stay visible; nothing further is written back.
          out_valid     <= 1'b0;
          out_reg_write <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int REG_W  = 3;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              in_valid, in_mem_read, in_mem_write;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              in_reg_write, in_mem_to_reg, in_halt;
  logic [REG_W-1:0]  in_wreg;
  logic              stall;
  logic              out_valid, out_reg_write, out_mem_to_reg, out_halt, out_err;
  logic [REG_W-1:0]  out_wreg;
  logic [DATA_W-1:0] out_alu, out_mem_data;
  logic [1:0]        dbg_state;

  mem_access_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus();

  mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_halt(in_halt), .in_wreg(in_wreg),
    .stall(stall), .mem(mem_bus.master),
    .out_valid(out_valid), .out_reg_write(out_reg_write),
    .out_mem_to_reg(out_mem_to_reg), .out_halt(out_halt), .out_err(out_err),
    .out_wreg(out_wreg), .out_alu(out_alu), .out_mem_data(out_mem_data),
    .dbg_state(dbg_state)
  );

  // ---------------- types ----------------
  typedef struct packed {
    logic              valid, rd, wr, rw, m2r, halt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
  } instr_t;

  typedef struct packed {
    logic              valid, rw, m2r, halt, err;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] alu, mem_data;
  } res_t;

  typedef struct {
    instr_t            i;
    int                lat;
    logic [DATA_W-1:0] rdata;
    logic              exp_req, exp_wr;
    res_t              e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  res_t exp_q[$];

  // ---------------- helpers ----------------
  function automatic instr_t mk_i(input logic v, rd, wr, rw, m2r, halt,
                                  input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] wd,
                                  input logic [REG_W-1:0] wr_reg);
    instr_t t;
    t.valid = v; t.rd = rd; t.wr = wr; t.rw = rw; t.m2r = m2r; t.halt = halt;
    t.addr = a; t.wdata = wd; t.wreg = wr_reg;
    return t;
  endfunction

  function automatic res_t mk_r(input logic v, rw, m2r, halt, err,
                                input logic [REG_W-1:0] wr_reg,
                                input logic [DATA_W-1:0] alu, md);
    res_t r;
    r.valid = v; r.rw = rw; r.m2r = m2r; r.halt = halt; r.err = err;
    r.wreg = wr_reg; r.alu = alu; r.mem_data = md;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t = instr_t'({$urandom, $urandom});
    return t;
  endfunction

  // Reference model for aligned, non-halting traffic: what WB must see once
  // the instruction leaves MEM.
  function automatic res_t ref_result(input instr_t t, input logic [DATA_W-1:0] rdata);
    res_t r;
    if (t.valid && (t.rd || t.wr)) begin
      r = mk_r(1'b1, t.rw, t.m2r, t.halt, 1'b0, t.wreg, t.addr, t.rd ? rdata : '0);
    end else begin
      r = mk_r(t.valid, t.valid & t.rw, t.m2r, t.valid & t.halt, 1'b0,
               t.wreg, t.addr, '0);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    chk({tag, " out_valid"},      out_valid,      e.valid);
    chk({tag, " out_reg_write"},  out_reg_write,  e.rw);
    chk({tag, " out_mem_to_reg"}, out_mem_to_reg, e.m2r);
    chk({tag, " out_halt"},       out_halt,       e.halt);
    chk({tag, " out_err"},        out_err,        e.err);
    chk({tag, " out_wreg"},       out_wreg,       e.wreg);
    chk({tag, " out_alu"},        out_alu,        e.alu);
    chk({tag, " out_mem_data"},   out_mem_data,   e.mem_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input instr_t t);
    in_valid      = t.valid;
    in_mem_read   = t.rd;
    in_mem_write  = t.wr;
    in_reg_write  = t.rw;
    in_mem_to_reg = t.m2r;
    in_halt       = t.halt;
    in_addr       = t.addr;
    in_wdata      = t.wdata;
    in_wreg       = t.wreg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply('0);
    mem_bus.mem_done  = 1'b0;
    mem_bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the result is visible,
  // with a bubble on the inputs so a following call can issue back-to-back.
  task automatic run_instr(input instr_t t, input int lat, input logic [DATA_W-1:0] rdata,
                           input logic exp_req, input logic exp_wr, input res_t e,
                           input string tag);
    apply(t);
    mem_bus.mem_done = 1'b0;
    #1;
    chk({tag, " mem_req"}, mem_bus.mem_req, exp_req);
    if (exp_req) begin
      chk({tag, " issue stall"}, stall, 1'b1);
      chk({tag, " mem_wr"}, mem_bus.mem_wr, exp_wr);
      chk({tag, " mem_addr"}, mem_bus.mem_addr, t.addr);
      if (exp_wr) chk({tag, " mem_wdata"}, mem_bus.mem_wdata, t.wdata);
      @(negedge clk);
      for (int k = 1; k <= lat; k++) begin
        apply(rand_instr());  // must be ignored while waiting
        chk({tag, " wait out_valid"}, out_valid, 1'b0);
        if (k == lat) begin
          mem_bus.mem_rdata = rdata;
          mem_bus.mem_done  = 1'b1;
        end
        #1;
        chk({tag, " wait stall"}, stall, (k != lat));
        chk({tag, " wait mem_req"}, mem_bus.mem_req, 1'b0);
        @(negedge clk);
        mem_bus.mem_done  = 1'b0;
        mem_bus.mem_rdata = DATA_W'($urandom);
      end
    end else begin
      chk({tag, " stall"}, stall, 1'b0);
      @(negedge clk);
    end
    check_res(tag, e);
    apply('0);
  endtask

  // ---------------- test ----------------
  vec_t tbl[8];

  initial begin
    instr_t t;
    int lat;
    logic [DATA_W-1:0] rd;

    tbl[0] = '{mk_i(1,0,0,1,0,0,16'h1234,16'h0000,3'd5), 0, 16'h0,    0, 0,
               mk_r(1,1,0,0,0,3'd5,16'h1234,16'h0000)};
    tbl[1] = '{mk_i(1,1,0,1,1,0,16'h0040,16'h0000,3'd2), 3, 16'hBEEF, 1, 0,
               mk_r(1,1,1,0,0,3'd2,16'h0040,16'hBEEF)};
    tbl[2] = '{mk_i(1,0,1,0,0,0,16'h0010,16'hA5A5,3'd0), 1, 16'h5555, 1, 1,
               mk_r(1,0,0,0,0,3'd0,16'h0010,16'h0000)};
    tbl[3] = '{mk_i(0,1,1,1,1,1,16'h0ABD,16'h1111,3'd6), 0, 16'h0,    0, 0,
               mk_r(0,0,1,0,0,3'd6,16'h0ABD,16'h0000)};
    tbl[4] = '{mk_i(1,1,1,1,1,0,16'h0102,16'h3333,3'd7), 2, 16'h1111, 1, 0,
               mk_r(1,1,1,0,0,3'd7,16'h0102,16'h1111)};
    tbl[5] = '{mk_i(1,0,0,1,0,0,16'h0007,16'h0000,3'd3), 0, 16'h0,    0, 0,
               mk_r(1,1,0,0,0,3'd3,16'h0007,16'h0000)};
    tbl[6] = '{mk_i(1,1,0,1,1,0,16'h0200,16'h0000,3'd1), 1, 16'hCAFE, 1, 0,
               mk_r(1,1,1,0,0,3'd1,16'h0200,16'hCAFE)};
    tbl[7] = '{mk_i(1,0,1,0,0,0,16'h0202,16'h0F0F,3'd4), 4, 16'h2222, 1, 1,
               mk_r(1,0,0,0,0,3'd4,16'h0202,16'h0000)};

    // Reset state
    do_reset();
    check_res("reset", '0);
    chk("reset stall", stall, 1'b0);
    chk("reset mem_req", mem_bus.mem_req, 1'b0);
    chk("reset state", dbg_state, ST_IDLE);

    // Directed table (entries 6 and 7 run back-to-back)
    for (int n = 0; n < 8; n++) begin
      run_instr(tbl[n].i, tbl[n].lat, tbl[n].rdata, tbl[n].exp_req, tbl[n].exp_wr,
                tbl[n].e, $sformatf("vec%0d", n));
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      t = rand_instr();
      t.halt = 1'b0;
      t.valid = ($urandom_range(0, 3) != 0);
      if (t.valid && (t.rd || t.wr)) t.addr[0] = 1'b0;
      lat = $urandom_range(1, 4);
      rd  = DATA_W'($urandom);
      exp_q.push_back(ref_result(t, rd));
      run_instr(t, lat, rd, t.valid && (t.rd || t.wr), t.wr && !t.rd,
                exp_q.pop_front(), "rnd");
    end

    // Halt then ALU op
    do_reset();
    apply(mk_i(1,0,0,0,0,1,16'h0600,16'h0,3'd1));
    #1 chk("halt stall", stall, 1'b0);
    @(negedge clk);
    chk("halt out_halt", out_halt, 1'b1);
    chk("halt out_valid", out_valid, 1'b1);
    apply(mk_i(1,0,0,1,0,0,16'h4321,16'h0,3'd6));
    #1 chk("halted stall", stall, 1'b1);
    @(negedge clk);
    chk("halted out_valid", out_valid, 1'b0);
    chk("halted out_halt", out_halt, 1'b1);
    chk("halted out_alu", out_alu, 16'h0600);
    chk("halted state", dbg_state, ST_HALTED);
    apply(mk_i(1,1,0,1,1,0,16'h0044,16'h0,3'd2));
    #1 chk("halted mem_req", mem_bus.mem_req, 1'b0);
    @(negedge clk);
    chk("halted out_valid2", out_valid, 1'b0);

    // Misaligned load traps and freezes the pipe
    do_reset();
    apply(mk_i(1,1,0,1,1,0,16'h0003,16'h0,3'd2));
    #1 chk("misal mem_req", mem_bus.mem_req, 1'b0);
    @(negedge clk);
    chk("misal out_err", out_err, 1'b1);
    chk("misal out_halt", out_halt, 1'b1);
    chk("misal out_valid", out_valid, 1'b1);
    chk("misal out_reg_write", out_reg_write, 1'b0);
    chk("misal stall", stall, 1'b1);
    apply(mk_i(1,1,0,1,1,0,16'h0008,16'h0,3'd2));
    #1 chk("misal later mem_req", mem_bus.mem_req, 1'b0);
    @(negedge clk);
    chk("misal later out_valid", out_valid, 1'b0);
    chk("misal later out_err", out_err, 1'b1);
    chk("misal later stall", stall, 1'b1);

    // Reset while an access is outstanding; the late done is ignored
    do_reset();
    apply(mk_i(1,1,0,1,1,0,16'h0080,16'h0,3'd3));
    #1 chk("rstw mem_req", mem_bus.mem_req, 1'b1);
    @(negedge clk);
    apply('0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_res("rstw", '0);
    chk("rstw state", dbg_state, ST_IDLE);
    @(negedge clk);
    mem_bus.mem_rdata = 16'hFFFF;
    mem_bus.mem_done  = 1'b1;
    #1 chk("rstw late stall", stall, 1'b0);
    @(negedge clk);
    mem_bus.mem_done = 1'b0;
    check_res("rstw late", '0);
    chk("rstw late state", dbg_state, ST_IDLE);
    run_instr(mk_i(1,1,0,1,1,0,16'h0082,16'h0,3'd3), 1, 16'h1357, 1'b1, 1'b0,
              mk_r(1,1,1,0,0,3'd3,16'h0082,16'h1357), "rstw fresh");

    // Halt carried on a load completes the access, then freezes
    run_instr(mk_i(1,1,0,1,1,1,16'h00A0,16'h0,3'd5), 2, 16'h7777, 1'b1, 1'b0,
              mk_r(1,1,1,1,0,3'd5,16'h00A0,16'h7777), "halt load");
    apply(mk_i(1,1,0,1,1,0,16'h00A2,16'h0,3'd5));
    #1;
    chk("halt load stall", stall, 1'b1);
    chk("halt load mem_req", mem_bus.mem_req, 1'b0);
    chk("halt load state", dbg_state, ST_HALTED);
    @(negedge clk);
    chk("halt load out_valid", out_valid, 1'b0);
    chk("halt load out_halt", out_halt, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
